instr_mem_loadable: RTL and testbench

//  Parametrised, byte-lane-banked instruction memory for the single-cycle RISC-V core.
//  - NUM_LANES independent byte banks, each LANE_W bits wide.
//  - Registered fetch port; byte-strobed write port.
//  - Built-in boot loader: fills memory from a byte stream before the core starts fetching.

---
 rtl/instr_mem_pkg.sv | 22 ++
 rtl/instr_mem_if.sv | 53 +++++
 rtl/instr_mem_lane.sv | 61 ++++++
 rtl/instr_mem_loadable.sv | 131 +++++++++++++
 tb/tb_instr_mem_loadable.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_mem_pkg.sv
// Shared constants for the loadable, byte-lane-banked instruction memory.
// Build option: INSTR_MEM_PARITY_EN adds an even-parity bit per stored lane.
package instr_mem_pkg;

  localparam int LANE_W_DEF    = 8;
  localparam int NUM_LANES_DEF = 4;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

`ifdef INSTR_MEM_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif

  function automatic int word_w(input int lane_w, input int num_lanes);
    return lane_w * num_lanes;
  endfunction

endpackage

// File: rtl/instr_mem_if.sv
// Fetch, write and boot-loader signals of the instruction memory.
// Build option: INSTR_MEM_PARITY_EN adds the par_err output.
interface instr_mem_if
  import instr_mem_pkg::*;
#(
  parameter int LANE_W    = LANE_W_DEF,
  parameter int NUM_LANES = NUM_LANES_DEF,
  parameter int ADDR_W    = 10,
  parameter int LEN_W     = ADDR_W + 1
);

  localparam int WORD_W = word_w(LANE_W, NUM_LANES);

  logic                 fetch_req;
  logic [ADDR_W-1:0]    fetch_addr;
  logic                 fetch_ready;
  logic                 fetch_valid;
  logic [WORD_W-1:0]    fetch_rdata;
  logic                 we;
  logic [NUM_LANES-1:0] wstrb;
  logic [ADDR_W-1:0]    waddr;
  logic [WORD_W-1:0]    wdata;
  logic                 ld_start;
  logic [ADDR_W-1:0]    ld_base;
  logic [LEN_W-1:0]     ld_len;
  logic                 ld_valid;
  logic [LANE_W-1:0]    ld_data;
  logic                 ld_ready;
  logic                 ld_done;
  logic                 busy;
`ifdef INSTR_MEM_PARITY_EN
  logic                 par_err;
`endif

  modport master (
    output fetch_req, fetch_addr, we, wstrb, waddr, wdata,
    output ld_start, ld_base, ld_len, ld_valid, ld_data,
    input  fetch_ready, fetch_valid, fetch_rdata, ld_ready, ld_done, busy
`ifdef INSTR_MEM_PARITY_EN
    , input par_err
`endif
  );

  modport slave (
    input  fetch_req, fetch_addr, we, wstrb, waddr, wdata,
    input  ld_start, ld_base, ld_len, ld_valid, ld_data,
    output fetch_ready, fetch_valid, fetch_rdata, ld_ready, ld_done, busy
`ifdef INSTR_MEM_PARITY_EN
    , output par_err
`endif
  );

endinterface

// File: rtl/instr_mem_lane.sv
// One byte bank: synchronous write, registered read (read-first on same address).
// Build option: INSTR_MEM_PARITY_EN stores an even-parity bit alongside each entry.
module instr_mem_lane
  import instr_mem_pkg::*;
#(
  parameter int W      = LANE_W_DEF,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [W-1:0]      i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
`ifdef INSTR_MEM_PARITY_EN
  output logic              o_perr,
`endif
  output logic [W-1:0]      o_rdata
);

  logic [W+PAR_BITS-1:0] r_mem [2**ADDR_W];
  logic [W-1:0]          r_rdata;
  logic [W+PAR_BITS-1:0] w_rdWord;

  assign w_rdWord = r_mem[i_raddr];
  assign o_rdata  = r_rdata;

  // Storage is deliberately left out of reset so boot-loaded code survives it.
  always_ff @(posedge clk) begin
    if (i_we) begin
`ifdef INSTR_MEM_PARITY_EN
      r_mem[i_waddr] <= {^i_wdata, i_wdata};
`else
      r_mem[i_waddr] <= i_wdata;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= w_rdWord[W-1:0];
    end
  end

`ifdef INSTR_MEM_PARITY_EN
  logic r_perr;
  assign o_perr = r_perr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perr <= 1'b0;
    end else if (i_re) begin
      r_perr <= ^w_rdWord;
    end
  end
`endif

endmodule

// File: rtl/instr_mem_loadable.sv
// Byte-lane-banked instruction memory with registered fetch and a byte-stream boot loader.
// Build option: INSTR_MEM_PARITY_EN enables per-lane parity and the par_err output.
module instr_mem_loadable
  import instr_mem_pkg::*;
#(
  parameter int LANE_W    = LANE_W_DEF,
  parameter int NUM_LANES = NUM_LANES_DEF,
  parameter int ADDR_W    = 10,
  parameter int LEN_W     = ADDR_W + 1
) (
  input  logic       clk,
  input  logic       rst,
  instr_mem_if.slave bus
);

  localparam int WORD_W = word_w(LANE_W, NUM_LANES);
  localparam int LI_W   = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  logic [1:0]          r_state;
  logic [ADDR_W-1:0]   r_ptr;
  logic [LEN_W-1:0]    r_cnt;
  logic [LI_W-1:0]     r_laneIdx;
  logic [WORD_W-1:0]   r_buf;
  logic                r_fetchValid;

  logic                 w_idle;
  logic                 w_load;
  logic                 w_lastLane;
  logic                 w_loadWrite;
  logic                 w_fetchAcc;
  logic [WORD_W-1:0]    w_ldWord;
  logic [WORD_W-1:0]    w_wdata;
  logic [ADDR_W-1:0]    w_waddr;
  logic [WORD_W-1:0]    w_rdata;
  logic [NUM_LANES-1:0] w_laneWe;

  assign w_idle      = (r_state == S_IDLE);
  assign w_load      = (r_state == S_LOAD);
  assign w_lastLane  = (r_laneIdx == LI_W'(NUM_LANES - 1));
  assign w_loadWrite = w_load & bus.ld_valid & w_lastLane;
  assign w_fetchAcc  = w_idle & bus.fetch_req;

  // The final byte of a word bypasses the buffer so the word lands on the same edge.
  always_comb begin
    w_ldWord = r_buf;
    w_ldWord[(NUM_LANES-1)*LANE_W +: LANE_W] = bus.ld_data;
  end

  assign w_wdata = w_loadWrite ? w_ldWord : bus.wdata;
  assign w_waddr = w_loadWrite ? r_ptr    : bus.waddr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_ptr     <= '0;
      r_cnt     <= '0;
      r_laneIdx <= '0;
      r_buf     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.ld_start) begin
            r_ptr     <= bus.ld_base;
            r_cnt     <= bus.ld_len;
            r_laneIdx <= '0;
            r_state   <= (bus.ld_len == '0) ? S_DONE : S_LOAD;
          end
        end
        S_LOAD: begin
          if (bus.ld_valid) begin
            r_buf[int'(r_laneIdx)*LANE_W +: LANE_W] <= bus.ld_data;
            if (w_lastLane) begin
              r_laneIdx <= '0;
              r_ptr     <= r_ptr + ADDR_W'(1);
              r_cnt     <= r_cnt - LEN_W'(1);
              if (r_cnt == LEN_W'(1)) begin
                r_state <= S_DONE;
              end
            end else begin
              r_laneIdx <= r_laneIdx + LI_W'(1);
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetchValid <= 1'b0;
    end else begin
      r_fetchValid <= w_fetchAcc;
    end
  end

`ifdef INSTR_MEM_PARITY_EN
  logic [NUM_LANES-1:0] w_perr;
  assign bus.par_err = r_fetchValid & (|w_perr);
`endif

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    assign w_laneWe[g] = w_loadWrite | (w_idle & bus.we & bus.wstrb[g]);

    instr_mem_lane #(
      .W      (LANE_W),
      .ADDR_W (ADDR_W)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .i_we    (w_laneWe[g]),
      .i_waddr (w_waddr),
      .i_wdata (w_wdata[g*LANE_W +: LANE_W]),
      .i_re    (w_fetchAcc),
      .i_raddr (bus.fetch_addr),
`ifdef INSTR_MEM_PARITY_EN
      .o_perr  (w_perr[g]),
`endif
      .o_rdata (w_rdata[g*LANE_W +: LANE_W])
    );
  end

  assign bus.fetch_ready = w_idle;
  assign bus.fetch_valid = r_fetchValid;
  assign bus.fetch_rdata = w_rdata;
  assign bus.ld_ready    = w_load;
  assign bus.ld_done     = (r_state == S_DONE);
  assign bus.busy        = ~w_idle;

endmodule

// File: tb/tb_instr_mem_loadable.sv
// Self-checking bench for instr_mem_loadable against a word/byte-array reference model.
// Define INSTR_MEM_PARITY_EN to also exercise the parity-error path.
module tb_instr_mem_loadable;

  localparam int LW    = 8;
  localparam int NL    = 4;
  localparam int AW    = 10;
  localparam int LENW  = AW + 1;
  localparam int DEPTH = 2**AW;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  instr_mem_if #(.LANE_W(LW), .NUM_LANES(NL), .ADDR_W(AW), .LEN_W(LENW)) bus ();

  instr_mem_loadable #(.LANE_W(LW), .NUM_LANES(NL), .ADDR_W(AW), .LEN_W(LENW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  int obsViol;

  logic [31:0] mdl [DEPTH];
  logic [3:0]  kn  [DEPTH];
  logic [7:0]  ldBytes [64];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] maskOf(input int a);
    logic [31:0] m;
    m = '0;
    for (int l = 0; l < NL; l++) m[l*8 +: 8] = {8{kn[a][l]}};
    return m;
  endfunction

  task automatic model_write(input int a, input logic [31:0] d, input logic [3:0] s);
    for (int l = 0; l < NL; l++) begin
      if (s[l]) begin
        mdl[a][l*8 +: 8] = d[l*8 +: 8];
        kn[a][l] = 1'b1;
      end
    end
  endtask

  // A completed load word k is bytes 4k..4k+3, little-endian, at (base+k) mod depth.
  task automatic model_load(input int base, input int words);
    for (int k = 0; k < words; k++) begin
      mdl[(base + k) % DEPTH] = {ldBytes[4*k+3], ldBytes[4*k+2], ldBytes[4*k+1], ldBytes[4*k]};
      kn[(base + k) % DEPTH]  = 4'hF;
    end
  endtask

  task automatic do_write(input int a, input logic [31:0] d, input logic [3:0] s);
    bus.we = 1'b1; bus.waddr = AW'(a); bus.wdata = d; bus.wstrb = s;
    tick();
    bus.we = 1'b0;
    model_write(a, d, s);
  endtask

  task automatic do_fetch(input int a, output logic [31:0] d, output logic v);
    bus.fetch_req = 1'b1; bus.fetch_addr = AW'(a);
    tick();
    bus.fetch_req = 1'b0;
    v = bus.fetch_valid;
    d = bus.fetch_rdata;
  endtask

  // Streams nBytes with random gaps while poking fetch/write/start, which must all be ignored.
  task automatic stream_bytes(input int base, input int len, input int nBytes);
    obsViol = 0;
    bus.ld_start = 1'b1; bus.ld_base = AW'(base); bus.ld_len = LENW'(len);
    tick();
    bus.ld_start = 1'b0;
    for (int i = 0; i < nBytes; i++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g <= gap; g++) begin
        bus.ld_valid   = (g == gap);
        bus.ld_data    = (g == gap) ? ldBytes[i] : 8'($urandom);
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = AW'($urandom_range(0, DEPTH-1));
        bus.we = 1'b1; bus.waddr = AW'(100); bus.wdata = $urandom; bus.wstrb = 4'hF;
        bus.ld_start = $urandom_range(0, 1) == 1; bus.ld_base = AW'(200); bus.ld_len = '0;
        #1;
        if (bus.fetch_ready !== 1'b0 || bus.ld_ready !== 1'b1 ||
            bus.ld_done !== 1'b0 || bus.busy !== 1'b1) obsViol++;
        tick();
        if (bus.fetch_valid !== 1'b0) obsViol++;
      end
    end
    bus.ld_valid = 1'b0; bus.fetch_req = 1'b0; bus.we = 1'b0; bus.ld_start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    total++; if (bus.fetch_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_fetch_valid got=%b exp=0", bus.fetch_valid); end
    total++; if (bus.fetch_rdata !== 32'h0) begin bad++; $display("[TB] FAIL rst_fetch_rdata got=%h exp=0", bus.fetch_rdata); end
    total++; if (bus.ld_ready !== 1'b0) begin bad++; $display("[TB] FAIL rst_ld_ready got=%b exp=0", bus.ld_ready); end
    total++; if (bus.ld_done !== 1'b0) begin bad++; $display("[TB] FAIL rst_ld_done got=%b exp=0", bus.ld_done); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("[TB] FAIL rst_busy got=%b exp=0", bus.busy); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_write_strobe();
    logic [31:0] d;
    logic v;
    do_write(5, 32'hDEADBEEF, 4'b1111);
    do_write(5, 32'h0000AA00, 4'b0010);
    do_fetch(5, d, v);
    total++; if (v !== 1'b1) begin bad++; $display("[TB] FAIL strobe_valid got=%b exp=1", v); end
    total++; if (d !== 32'hDEADAAEF) begin bad++; $display("[TB] FAIL strobe_data got=%h exp=deadaaef", d); end
    tick();
    total++; if (bus.fetch_valid !== 1'b0) begin bad++; $display("[TB] FAIL valid_drop got=%b exp=0", bus.fetch_valid); end
    total++; if (bus.fetch_rdata !== 32'hDEADAAEF) begin bad++; $display("[TB] FAIL rdata_hold got=%h exp=deadaaef", bus.fetch_rdata); end
    // Same-cycle write and fetch of one address returns the old word.
    bus.we = 1'b1; bus.waddr = AW'(5); bus.wdata = 32'h12345678; bus.wstrb = 4'hF;
    bus.fetch_req = 1'b1; bus.fetch_addr = AW'(5);
    tick();
    bus.we = 1'b0; bus.fetch_req = 1'b0;
    total++; if (bus.fetch_rdata !== 32'hDEADAAEF) begin bad++; $display("[TB] FAIL read_first got=%h exp=deadaaef", bus.fetch_rdata); end
    model_write(5, 32'h12345678, 4'hF);
    do_fetch(5, d, v);
    total++; if (d !== mdl[5]) begin bad++; $display("[TB] FAIL after_rf_write got=%h exp=%h", d, mdl[5]); end
  endtask

  task automatic check_done_pulse(input string tag);
    int doneCnt;
    logic firstDone;
    doneCnt = 0;
    firstDone = bus.ld_done;
    for (int c = 0; c < 4; c++) begin
      if (bus.ld_done === 1'b1) doneCnt++;
      tick();
    end
    total++; if (firstDone !== 1'b1) begin bad++; $display("[TB] FAIL %s_done_latency got=%b exp=1", tag, firstDone); end
    total++; if (doneCnt != 1) begin bad++; $display("[TB] FAIL %s_done_count got=%0d exp=1", tag, doneCnt); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("[TB] FAIL %s_busy_end got=%b exp=0", tag, bus.busy); end
    total++; if (obsViol != 0) begin bad++; $display("[TB] FAIL %s_load_phase got=%0d exp=0 violations", tag, obsViol); end
  endtask

  task automatic test_load();
    logic [31:0] d;
    logic v;
    do_write(100, 32'hCAFEF00D, 4'hF);
    for (int i = 0; i < 8; i++) ldBytes[i] = 8'(8'h11 * (i + 1));
    stream_bytes(8, 2, 8);
    check_done_pulse("load");
    model_load(8, 2);
    do_fetch(8, d, v);
    total++; if (v !== 1'b1 || d !== 32'h44332211) begin bad++; $display("[TB] FAIL load_word0 got=%h v=%b exp=44332211", d, v); end
    do_fetch(9, d, v);
    total++; if (d !== 32'h88776655) begin bad++; $display("[TB] FAIL load_word1 got=%h exp=88776655", d); end
    do_fetch(100, d, v);
    total++; if (d !== mdl[100]) begin bad++; $display("[TB] FAIL write_during_load got=%h exp=%h", d, mdl[100]); end
  endtask

  task automatic test_load_wrap();
    logic [31:0] d;
    logic v;
    for (int i = 0; i < 8; i++) ldBytes[i] = 8'($urandom);
    stream_bytes(DEPTH-1, 2, 8);
    check_done_pulse("wrap");
    model_load(DEPTH-1, 2);
    do_fetch(DEPTH-1, d, v);
    total++; if (d !== mdl[DEPTH-1]) begin bad++; $display("[TB] FAIL wrap_last got=%h exp=%h", d, mdl[DEPTH-1]); end
    do_fetch(0, d, v);
    total++; if (d !== mdl[0]) begin bad++; $display("[TB] FAIL wrap_zero got=%h exp=%h", d, mdl[0]); end
  endtask

  task automatic test_reset_midload();
    logic [31:0] d;
    logic v;
    do_write(41, $urandom, 4'hF);
    for (int i = 0; i < 8; i++) ldBytes[i] = 8'($urandom);
    stream_bytes(40, 2, 6);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if (bus.busy !== 1'b0 || bus.ld_ready !== 1'b0) begin bad++; $display("[TB] FAIL midrst_idle got busy=%b rdy=%b exp=0/0", bus.busy, bus.ld_ready); end
    total++; if (obsViol != 0) begin bad++; $display("[TB] FAIL midrst_load_phase got=%0d exp=0 violations", obsViol); end
    model_load(40, 1);
    do_fetch(40, d, v);
    total++; if (d !== mdl[40]) begin bad++; $display("[TB] FAIL midrst_first got=%h exp=%h", d, mdl[40]); end
    do_fetch(41, d, v);
    total++; if (d !== mdl[41]) begin bad++; $display("[TB] FAIL midrst_keep got=%h exp=%h", d, mdl[41]); end
    bus.ld_start = 1'b1; bus.ld_base = AW'(300); bus.ld_len = '0;
    tick();
    bus.ld_start = 1'b0;
    total++; if (bus.ld_done !== 1'b1) begin bad++; $display("[TB] FAIL zero_len_done got=%b exp=1", bus.ld_done); end
    tick();
    total++; if (bus.ld_done !== 1'b0 || bus.busy !== 1'b0) begin bad++; $display("[TB] FAIL zero_len_end got done=%b busy=%b exp=0/0", bus.ld_done, bus.busy); end
  endtask

  task automatic test_back_to_back();
    for (int a = 60; a < 64; a++) do_write(a, $urandom, 4'hF);
    bus.fetch_req = 1'b1;
    for (int a = 60; a < 64; a++) begin
      bus.fetch_addr = AW'(a);
      tick();
      total++; if (bus.fetch_valid !== 1'b1 || bus.fetch_rdata !== mdl[a]) begin bad++; $display("[TB] FAIL b2b_%0d got=%h v=%b exp=%h", a, bus.fetch_rdata, bus.fetch_valid, mdl[a]); end
    end
    bus.fetch_req = 1'b0;
    tick();
    total++; if (bus.fetch_valid !== 1'b0) begin bad++; $display("[TB] FAIL b2b_end got=%b exp=0", bus.fetch_valid); end
  endtask

  task automatic test_random();
    logic [31:0] d;
    logic [31:0] m;
    logic v;
    int a;
    for (int it = 0; it < 80; it++) begin
      a = $urandom_range(0, 15);
      if ($urandom_range(0, 1) == 0) begin
        do_write(a, $urandom, 4'($urandom_range(0, 15)));
      end else begin
        do_fetch(a, d, v);
        m = maskOf(a);
        total++; if (v !== 1'b1 || (d & m) !== (mdl[a] & m)) begin bad++; $display("[TB] FAIL rand_fetch_%0d got=%h v=%b exp=%h mask=%h", a, d, v, mdl[a], m); end
      end
    end
  endtask

`ifdef INSTR_MEM_PARITY_EN
  task automatic test_parity();
    logic [31:0] d;
    logic v;
    do_write(3, $urandom, 4'hF);
    do_fetch(3, d, v);
    total++; if (bus.par_err !== 1'b0) begin bad++; $display("[TB] FAIL par_clean got=%b exp=0", bus.par_err); end
    dut.g_lane[1].u_lane.r_mem[3][0] = ~dut.g_lane[1].u_lane.r_mem[3][0];
    do_fetch(3, d, v);
    total++; if (v !== 1'b1 || bus.par_err !== 1'b1) begin bad++; $display("[TB] FAIL par_flip got par=%b v=%b exp=1/1", bus.par_err, v); end
    tick();
    total++; if (bus.par_err !== 1'b0) begin bad++; $display("[TB] FAIL par_idle got=%b exp=0", bus.par_err); end
  endtask
`endif

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mdl[i] = '0;
      kn[i]  = '0;
    end
    bus.fetch_req = 1'b0; bus.fetch_addr = '0;
    bus.we = 1'b0; bus.wstrb = '0; bus.waddr = '0; bus.wdata = '0;
    bus.ld_start = 1'b0; bus.ld_base = '0; bus.ld_len = '0;
    bus.ld_valid = 1'b0; bus.ld_data = '0;
    $display("[TB] start");
    test_reset();
    test_write_strobe();
    test_load();
    test_load_wrap();
    test_reset_midload();
    test_back_to_back();
    test_random();
`ifdef INSTR_MEM_PARITY_EN
    test_parity();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
